// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Predicts from FetchPC in IF, trains on the EX branch outcome and flags mispredictions.
module branch_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] FetchPC,
  output logic        PredTaken,
  output logic [31:0] PredTarget,
  input  logic        UpdValid,
  input  logic [31:0] UpdPC,
  input  logic        UpdTaken,
  input  logic [31:0] UpdTarget,
  input  logic        UpdPredTaken,
  input  logic [31:0] UpdPredTarget,
  output logic        Mispredict,
  output logic [31:0] RedirectPC,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = 32 - INDEX_W - 2;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [31:0]      r_brCount;
  logic [31:0]      r_missCount;

  logic [INDEX_W-1:0] w_fIdx;
  logic [TAG_W-1:0]   w_fTag;
  logic               w_fHit;
  logic [INDEX_W-1:0] w_uIdx;
  logic [TAG_W-1:0]   w_uTag;
  logic               w_uHit;

  assign w_fIdx = FetchPC[INDEX_W+1:2];
  assign w_fTag = FetchPC[31:INDEX_W+2];
  assign w_fHit = r_valid[w_fIdx] && (r_tag[w_fIdx] == w_fTag);
  assign w_uIdx = UpdPC[INDEX_W+1:2];
  assign w_uTag = UpdPC[31:INDEX_W+2];
  assign w_uHit = r_valid[w_uIdx] && (r_tag[w_uIdx] == w_uTag);

  // Lookup reads only stored state, so a same-cycle update is seen one cycle later.
  always_comb begin
    PredTaken  = rst_n && w_fHit && r_ctr[w_fIdx][1];
    PredTarget = PredTaken ? r_target[w_fIdx] : FetchPC + 32'd4;
  end

  always_comb begin
    Mispredict = UpdValid && rst_n &&
                 ((UpdTaken != UpdPredTaken) ||
                  (UpdTaken && UpdPredTaken && (UpdTarget != UpdPredTarget)));
    RedirectPC = UpdTaken ? UpdTarget : UpdPC + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (UpdValid) begin
      if (w_uHit) begin
        if (UpdTaken) begin
          if (r_ctr[w_uIdx] != 2'b11) r_ctr[w_uIdx] <= r_ctr[w_uIdx] + 2'd1;
          r_target[w_uIdx] <= UpdTarget;
        end else if (r_ctr[w_uIdx] != 2'b00) begin
          r_ctr[w_uIdx] <= r_ctr[w_uIdx] - 2'd1;
        end
      end else if (UpdTaken) begin
        // Taken misses claim the slot, evicting any aliasing branch.
        r_valid[w_uIdx]  <= 1'b1;
        r_tag[w_uIdx]    <= w_uTag;
        r_target[w_uIdx] <= UpdTarget;
        r_ctr[w_uIdx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brCount   <= '0;
      r_missCount <= '0;
    end else begin
      if (UpdValid && (r_brCount != 32'hFFFF_FFFF)) r_brCount <= r_brCount + 32'd1;
      if (Mispredict && (r_missCount != 32'hFFFF_FFFF)) r_missCount <= r_missCount + 32'd1;
    end
  end

  assign BrCount   = r_brCount;
  assign MissCount = r_missCount;

endmodule
